uart_rx_param_controller: RTL and testbench

UART_RX_PARAM_CONTROLLER -- requirements
Module: uart_rx_param_controller

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx_param_controller.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_param_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_t : receiver state encoding
//   PARITY_*   : values accepted by the PARITY_MODE parameter
//   maj3       : 2-of-3 majority vote used for bit recovery
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO.
//   clk, rst    : clock, synchronous active-high reset (pointers/occupancy only)
//   push, din   : write request and data; ignored when full unless popping
//   pop         : read request; ignored when empty
//   dout        : head entry, forced to zero while empty
//   empty, full : occupancy flags
//   count       : exact occupancy 0..DEPTH
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_param_controller.sv
// Parameterised UART receiver with majority-vote bit recovery, parity and
// stop-bit checking, a receive FIFO and saturating error counters.
//   Clock_50      : single clock
//   Reset         : synchronous active-high reset
//   Enable        : allows a new start bit to be accepted (frames in flight finish)
//   UART_RX_I     : asynchronous serial input, idle high
//   Unload_data   : pop the FIFO head
//   Clear_errors  : zero Frame_error, Parity_error and Overrun
//   RX_data       : FIFO head, zero-extended above DATA_BITS
//   Empty/Full/Count : FIFO status
//   Overrun       : sticky, a good byte was dropped on a full FIFO
//   Frame_error / Parity_error : saturating event counters
module uart_rx_param_controller
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          Clock_50,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          UART_RX_I,
  input  logic                          Unload_data,
  input  logic                          Clear_errors,
  output logic [7:0]                    RX_data,
  output logic                          Empty,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          Overrun,
  output logic [3:0]                    Frame_error,
  output logic [3:0]                    Parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SMP_B   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] SMP_C   = CW'(CLKS_PER_BIT / 2 + 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  rx_state_t              state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic                   par_fail;
  logic                   smp_a, smp_b, smp_c;
  logic                   smp_c_now;
  logic                   bit_val;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   shreg;
  logic [7:0]             rx_byte;
  logic                   stop_ok_last;
  logic                   push;
  logic                   fe_evt;
  logic                   pe_evt;
  logic                   ovr_evt;

  // With small CLKS_PER_BIT the third sample lands on the resolve count,
  // so it is taken straight from the line in that case.
  assign smp_c_now = (cnt == SMP_C) ? rx_s : smp_c;
  assign bit_val   = maj3(smp_a, smp_b, smp_c_now);
  assign bit_end   = (cnt == CNT_MAX);

  assign stop_ok_last = (state == ST_STOP) && bit_end && bit_val &&
                        (stop_idx == 1'(STOP_BITS - 1));
  assign push    = stop_ok_last && !par_fail;
  assign pe_evt  = stop_ok_last && par_fail;
  assign fe_evt  = (state == ST_STOP) && bit_end && !bit_val;
  assign ovr_evt = push && Full && !Unload_data;
  assign rx_byte = 8'(shreg);

  // Stage: line synchroniser and frame FSM
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state    <= ST_IDLE;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_fail <= 1'b0;
    end else begin
      rx_meta <= UART_RX_I;
      rx_s    <= rx_meta;
      if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
        cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (Enable && !rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            if (bit_val) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              par_fail <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state    <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end
          end
        end
        ST_PARITY: begin
          // Ones across data+parity must be even (even mode) or odd (odd mode).
          if (bit_end) begin
            par_fail <= (^shreg) ^ bit_val ^ (PARITY_MODE == PARITY_ODD);
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!bit_val)                               state <= ST_BREAK_WAIT;
            else if (stop_idx == 1'(STOP_BITS - 1))     state <= ST_IDLE;
            else                                        stop_idx <= stop_idx + 1'b1;
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage: sample capture and data shift (datapath, no reset)
  always_ff @(posedge Clock_50) begin
    if (cnt == SMP_A) smp_a <= rx_s;
    if (cnt == SMP_B) smp_b <= rx_s;
    if (cnt == SMP_C) smp_c <= rx_s;
    if (state == ST_DATA && bit_end) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
  end

  // Stage: error counters; an event coinciding with a clear still registers
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      Frame_error  <= '0;
      Parity_error <= '0;
      Overrun      <= 1'b0;
    end else begin
      Frame_error  <= Clear_errors ? {3'b000, fe_evt}
                                   : (fe_evt ? sat_inc(Frame_error) : Frame_error);
      Parity_error <= Clear_errors ? {3'b000, pe_evt}
                                   : (pe_evt ? sat_inc(Parity_error) : Parity_error);
      Overrun      <= ovr_evt | (Overrun & ~Clear_errors);
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clock_50),
    .rst   (Reset),
    .push  (push),
    .pop   (Unload_data),
    .din   (rx_byte),
    .dout  (RX_data),
    .empty (Empty),
    .full  (Full),
    .count (Count)
  );

endmodule

// File: tb/tb_uart_rx_param_controller.sv
// Bench for uart_rx_param_controller: three receiver configurations
// (8N1, 8E1, 7N2; 8 clocks per bit, 4-deep FIFO) driven by a frame
// generator and compared against a queue-based model of received bytes
// and error counts.
module tb_uart_rx_param_controller;

  localparam int CPB = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    bit         par_flip;
    bit         stop_bad;
    bit         exp_push;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] line;
  logic [2:0] unload;
  logic [2:0] clr;
  logic [7:0] rxd [3];
  logic [2:0] emp;
  logic [2:0] ful;
  logic [2:0] cnt [3];
  logic [2:0] ovr;
  logic [3:0] fe [3];
  logic [3:0] pe [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$], q1[$], q2[$];
  int m_fe [3];
  int m_pe [3];
  int m_ovr[3];

  uart_rx_param_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                             .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .Clock_50(clk), .Reset(rst), .Enable(en), .UART_RX_I(line[0]),
    .Unload_data(unload[0]), .Clear_errors(clr[0]), .RX_data(rxd[0]),
    .Empty(emp[0]), .Full(ful[0]), .Count(cnt[0]), .Overrun(ovr[0]),
    .Frame_error(fe[0]), .Parity_error(pe[0]));

  uart_rx_param_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
                             .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
    .Clock_50(clk), .Reset(rst), .Enable(en), .UART_RX_I(line[1]),
    .Unload_data(unload[1]), .Clear_errors(clr[1]), .RX_data(rxd[1]),
    .Empty(emp[1]), .Full(ful[1]), .Count(cnt[1]), .Overrun(ovr[1]),
    .Frame_error(fe[1]), .Parity_error(pe[1]));

  uart_rx_param_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0),
                             .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u2 (
    .Clock_50(clk), .Reset(rst), .Enable(en), .UART_RX_I(line[2]),
    .Unload_data(unload[2]), .Clear_errors(clr[2]), .RX_data(rxd[2]),
    .Empty(emp[2]), .Full(ful[2]), .Count(cnt[2]), .Overrun(ovr[2]),
    .Frame_error(fe[2]), .Parity_error(pe[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int db_of(input int w); return (w == 2) ? 7 : 8; endfunction
  function automatic int pm_of(input int w); return (w == 1) ? 1 : 0; endfunction
  function automatic int sb_of(input int w); return (w == 2) ? 2 : 1; endfunction
  function automatic int sat(input int v);   return (v < 15) ? v + 1 : 15; endfunction

  function automatic int qsize(input int w);
    case (w)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qhead(input int w);
    case (w)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int w, input logic [7:0] b);
    case (w)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic qpop(input int w);
    case (w)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      m_fe[i] = 0; m_pe[i] = 0; m_ovr[i] = 0;
    end
  endtask

  // Outcome of one whole frame: framing beats parity, good bytes queue or overflow.
  task automatic model_frame(input int w, input logic [7:0] data, input bit par_flip,
                             input bit stop_bad);
    logic [7:0] d;
    d = (db_of(w) == 7) ? (data & 8'h7F) : data;
    if (stop_bad)                       m_fe[w] = sat(m_fe[w]);
    else if (pm_of(w) != 0 && par_flip) m_pe[w] = sat(m_pe[w]);
    else if (qsize(w) == DEPTH)         m_ovr[w] = 1;
    else                                qpush(w, d);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_state(input int w, input string tag);
    check($sformatf("%s.count", tag),     int'(cnt[w]), qsize(w));
    check($sformatf("%s.empty", tag),     int'(emp[w]), int'(qsize(w) == 0));
    check($sformatf("%s.full", tag),      int'(ful[w]), int'(qsize(w) == DEPTH));
    if (qsize(w) > 0)
      check($sformatf("%s.head", tag),    int'(rxd[w]), int'(qhead(w)));
    check($sformatf("%s.overrun", tag),   int'(ovr[w]), m_ovr[w]);
    check($sformatf("%s.frame_err", tag), int'(fe[w]),  m_fe[w]);
    check($sformatf("%s.parity_err", tag),int'(pe[w]),  m_pe[w]);
  endtask

  // Drives one frame starting at a falling clock edge; ends at a falling edge
  // with the line idle. spike_bit selects a frame bit that gets a 1-cycle
  // inversion near its centre (-1 for none); hold_low stretches the last bit.
  task automatic send_frame(input int w, input logic [7:0] data, input bit par_flip,
                            input bit stop_bad, input int spike_bit, input int hold_low);
    bit         bits[$];
    logic [7:0] d;
    d = (db_of(w) == 7) ? (data & 8'h7F) : data;
    bits.push_back(1'b0);
    for (int i = 0; i < db_of(w); i++) bits.push_back(d[i]);
    if (pm_of(w) != 0) bits.push_back((^d) ^ (pm_of(w) == 2) ^ par_flip);
    for (int s = 0; s < sb_of(w); s++) bits.push_back(!stop_bad);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < CPB; c++) begin
        line[w] = (k == spike_bit && c == 5) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
    end
    repeat (hold_low) @(negedge clk);
    line[w] = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic pop(input int w);
    unload[w] = 1'b1;
    @(negedge clk);
    unload[w] = 1'b0;
    if (qsize(w) > 0) qpop(w);
  endtask

  task automatic clear(input int w);
    clr[w] = 1'b1;
    @(negedge clk);
    clr[w] = 1'b0;
    m_fe[w] = 0; m_pe[w] = 0; m_ovr[w] = 0;
  endtask

  // Good frame with Unload_data (kind 1) or Clear_errors (kind 2) held in
  // exactly the cycle the byte is pushed.
  task automatic send_strobe(input int w, input logic [7:0] d, input int kind);
    send_frame(w, d, 1'b0, 1'b0, -1, 0);
    @(negedge clk);
    @(negedge clk);
    if (kind == 1) unload[w] = 1'b1;
    else           clr[w]    = 1'b1;
    @(negedge clk);
    unload[w] = 1'b0;
    clr[w]    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t       vt[8];
    logic [7:0] rb;
    int         npop;

    vt[0] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b1; line = 3'b111; unload = 3'b000; clr = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      check_state(w, $sformatf("reset%0d", w));
      check($sformatf("reset%0d.rx_data", w), int'(rxd[w]), 0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: Empty must fall exactly one cycle after the last stop-bit count
    send_frame(0, 8'hA5, 1'b0, 1'b0, -1, 0);
    @(negedge clk);
    @(negedge clk);
    check("a5.empty_before_push", int'(emp[0]), 1);
    @(negedge clk);
    check("a5.empty_after_push", int'(emp[0]), 0);
    model_frame(0, 8'hA5, 1'b0, 1'b0);
    check_state(0, "a5");
    pop(0);
    check_state(0, "a5_pop");

    // 8E1 table: parity and framing outcomes
    for (int i = 0; i < 8; i++) begin
      send_frame(1, vt[i].data, vt[i].par_flip, vt[i].stop_bad, -1, 0);
      settle();
      if (vt[i].exp_push) qpush(1, vt[i].data);
      m_fe[1] = m_fe[1] + int'(vt[i].exp_fe);
      m_pe[1] = m_pe[1] + int'(vt[i].exp_pe);
      check_state(1, $sformatf("vec%0d", i));
      if (vt[i].exp_push) begin
        pop(1);
        check_state(1, $sformatf("vec%0d_pop", i));
      end
    end

    // Bad stop bit with the line held low afterwards, then saturation
    send_frame(0, 8'h3C, 1'b0, 1'b1, -1, 24);
    settle();
    model_frame(0, 8'h3C, 1'b0, 1'b1);
    check_state(0, "break_hold");
    for (int i = 0; i < 15; i++) begin
      send_frame(0, 8'(i * 17), 1'b0, 1'b1, -1, 0);
      settle();
      model_frame(0, 8'(i * 17), 1'b0, 1'b1);
    end
    check_state(0, "fe_saturate");
    clear(0);
    check_state(0, "fe_clear");

    // Fill past capacity, clear, then simultaneous push/pop and clear/overrun
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i * 8'h11), 1'b0, 1'b0, -1, 0);
      settle();
      model_frame(0, 8'(i * 8'h11), 1'b0, 1'b0);
      check_state(0, $sformatf("fill%0d", i));
    end
    clear(0);
    check_state(0, "ovr_clear");
    send_strobe(0, 8'h66, 1);
    qpop(0);
    qpush(0, 8'h66);
    check_state(0, "full_push_pop");
    send_strobe(0, 8'h77, 2);
    m_ovr[0] = 1;
    check_state(0, "clear_vs_overrun");
    for (int i = 0; i < 5; i++) begin
      pop(0);
      check_state(0, $sformatf("drain%0d", i));
    end
    send_strobe(0, 8'h88, 1);
    qpush(0, 8'h88);
    check_state(0, "empty_push_pop");
    pop(0);
    clear(0);

    // Short low glitch in IDLE, then single-cycle spikes inside data bits
    line[0] = 1'b0;
    repeat (3) @(negedge clk);
    line[0] = 1'b1;
    repeat (40) @(negedge clk);
    check_state(0, "glitch");
    send_frame(0, 8'hC3, 1'b0, 1'b0, 4, 0);
    settle();
    model_frame(0, 8'hC3, 1'b0, 1'b0);
    check_state(0, "spike_a");
    send_frame(0, 8'h0F, 1'b0, 1'b0, 7, 0);
    settle();
    model_frame(0, 8'h0F, 1'b0, 1'b0);
    check_state(0, "spike_b");
    pop(0);
    pop(0);

    // Randomised traffic on the 8N1 receiver
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      send_frame(0, rb, 1'b0, 1'b0, -1, 0);
      settle();
      model_frame(0, rb, 1'b0, 1'b0);
      check_state(0, $sformatf("rnd%0d", i));
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop(0);
        check_state(0, $sformatf("rnd%0d_pop%0d", i, p));
      end
    end

    // 7N2: normal frame, then reset in the middle of data bit 3
    send_frame(2, 8'h55, 1'b0, 1'b0, -1, 0);
    settle();
    model_frame(2, 8'h55, 1'b0, 1'b0);
    check_state(2, "7n2");
    pop(2);
    line[2] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      line[2] = k[0] ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    line[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    line[2] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    check_state(2, "midframe_reset");
    check_state(0, "midframe_reset_u0");
    send_frame(2, 8'h2A, 1'b0, 1'b0, -1, 0);
    settle();
    model_frame(2, 8'h2A, 1'b0, 1'b0);
    check_state(2, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
